// File: rtl/mips_cpu_bus_arbiter.sv
// Two-master arbiter that funnels instruction fetches and data loads/stores onto one Avalon master port.
// Tie-break policy: define ARB_ROUND_ROBIN_EN for round-robin, otherwise the data port wins ties.
module mips_cpu_bus_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_ack,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_ack,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        grant_data_q;
    logic [31:0] address_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] writedata_q;
    logic [3:0]  byteenable_q;
    logic [31:0] i_readdata_q;
    logic [31:0] d_readdata_q;
    logic        i_ack_q;
    logic        d_ack_q;

    logic        i_pend;
    logic        d_pend;
    logic        pick_data_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the data port received the most recent grant
    logic        last_data_q;
`endif

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    always_comb begin
        pick_data_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_pend && i_pend) begin
            pick_data_d = ~last_data_q;
        end else begin
            pick_data_d = d_pend;
        end
`else
        pick_data_d = d_pend;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_data_q <= 1'b0;
            address_q    <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'h0;
            i_readdata_q <= 32'h0;
            d_readdata_q <= 32'h0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_pend || d_pend) begin
                        grant_data_q <= pick_data_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_data_q  <= pick_data_d;
`endif
                        if (pick_data_d) begin
                            // Simultaneous read and write is issued as a write
                            address_q    <= d_address;
                            read_q       <= d_read & ~d_write;
                            write_q      <= d_write;
                            writedata_q  <= d_writedata;
                            byteenable_q <= d_byteenable;
                        end else begin
                            address_q    <= i_address;
                            read_q       <= 1'b1;
                            write_q      <= 1'b0;
                            writedata_q  <= 32'h0;
                            byteenable_q <= 4'hF;
                        end
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        if (read_q) begin
                            if (grant_data_q) begin
                                d_readdata_q <= readdata;
                            end else begin
                                i_readdata_q <= readdata;
                            end
                        end
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        i_ack_q <= ~grant_data_q;
                        d_ack_q <= grant_data_q;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign i_readdata = i_readdata_q;
    assign d_readdata = d_readdata_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Randomized and directed check of mips_cpu_bus_arbiter against a transaction-level arbitration model.
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_ack;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_ack;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    // Model state: last word delivered to each requester, and who was served last
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    bit          last_data;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_readdata  (i_readdata),
        .i_ack       (i_ack),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_writedata (d_writedata),
        .d_byteenable(d_byteenable),
        .d_readdata  (d_readdata),
        .d_ack       (d_ack),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One granted transaction: entered at posedge+1 in IDLE with the request already driven
    task automatic txn(input bit is_data, input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [31:0] wd, input logic [3:0] be, input int waits,
                       input logic [31:0] rdata);
        waitrequest = (waits > 0);
        readdata    = rdata;
        @(posedge clk); #1;
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            chk("bus_address", address, addr);
            chk("bus_read", 32'(read), 32'(rd));
            chk("bus_write", 32'(write), 32'(wr));
            chk("bus_byteenable", 32'(byteenable), 32'(be));
            if (wr) chk("bus_writedata", writedata, wd);
            chk("busy_i_ack", 32'(i_ack), 32'd0);
            chk("busy_d_ack", 32'(d_ack), 32'd0);
            @(posedge clk); #1;
            waitrequest = (c + 1 < waits);
        end
        @(negedge clk);
        if (rd) begin
            if (is_data) exp_drd = rdata;
            else         exp_ird = rdata;
        end
        chk("resp_read", 32'(read), 32'd0);
        chk("resp_write", 32'(write), 32'd0);
        chk("resp_i_ack", 32'(i_ack), 32'(!is_data));
        chk("resp_d_ack", 32'(d_ack), 32'(is_data));
        chk("resp_i_readdata", i_readdata, exp_ird);
        chk("resp_d_readdata", d_readdata, exp_drd);
        $display("txn %s addr=%h rd=%0d wr=%0d waits=%0d", is_data ? "data" : "inst", addr, rd, wr, waits);
        last_data = is_data;
        @(posedge clk); #1;
    endtask

    // Raise both requests together, then serve them in the order the arbitration rules dictate
    task automatic round(input bit ireq, input bit drd, input bit dwr,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [3:0] dbe, input int iw, input int dw,
                         input logic [31:0] ird, input logic [31:0] drdv);
        bit ipend;
        bit dpend;
        bit win_data;
        i_read = ireq; i_address = ia;
        d_read = drd; d_write = dwr; d_address = da; d_writedata = dwd; d_byteenable = dbe;
        ipend = ireq;
        dpend = drd | dwr;
        while (ipend || dpend) begin
            if (ipend && dpend) win_data = RR ? !last_data : 1'b1;
            else                win_data = dpend;
            if (win_data) begin
                txn(1'b1, da, drd & !dwr, dwr, dwd, dbe, dw, drdv);
                d_read = 1'b0; d_write = 1'b0; dpend = 1'b0;
            end else begin
                txn(1'b0, ia, 1'b1, 1'b0, 32'h0, 4'hF, iw, ird);
                i_read = 1'b0; ipend = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_writedata = 0; d_byteenable = 0;
        waitrequest = 0; readdata = 0;
        exp_ird = 0; exp_drd = 0; last_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_byteenable", 32'(byteenable), 32'd0);
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_i_readdata", i_readdata, 32'd0);
        chk("rst_d_readdata", d_readdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Boot fetch, zero wait
        round(1, 0, 0, 32'hBFC00000, 0, 0, 0, 0, 0, 32'h24020005, 0);
        // Partial store with 4 stall cycles
        round(0, 0, 1, 0, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 4, 0, 32'h5A5A5A5A);
        // Simultaneous requests, twice
        round(1, 1, 0, 32'h400, 32'h800, 0, 4'hF, 0, 1, 32'h11111111, 32'h22222222);
        round(1, 1, 0, 32'h404, 32'h804, 0, 4'hF, 1, 0, 32'h33333333, 32'h44444444);
        // Read and write together issue as a write
        round(0, 1, 1, 0, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h77777777);

        // Reset while stalled in BUS abandons the access
        d_read = 1; d_write = 0; d_address = 32'h3000; d_byteenable = 4'hF;
        waitrequest = 1; readdata = 32'h99999999;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_read", 32'(read), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_read", 32'(read), 32'd0);
        chk("async_rst_write", 32'(write), 32'd0);
        chk("async_rst_address", address, 32'd0);
        d_read = 0; waitrequest = 0;
        exp_ird = 0; exp_drd = 0; last_data = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_i_ack", 32'(i_ack), 32'd0);
            chk("post_rst_d_ack", 32'(d_ack), 32'd0);
            chk("post_rst_read", 32'(read), 32'd0);
        end
        @(posedge clk); #1;
        round(0, 1, 0, 0, 32'h3000, 0, 4'hF, 0, 0, 0, 32'hABCD1234);

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            bit ir;
            bit dr;
            bit dwv;
            ir  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            dwv = 1'($urandom_range(0, 1));
            round(ir, dr, dwv, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
